text_write_arbiter: RTL and testbench

TEXT_WRITE_ARBITER -- requirements
Module: text_write_arbiter

---
 rtl/text_write_arbiter_if.sv | 22 ++
 rtl/text_write_arbiter.sv | 166 ++++++++++++++++
 tb/tb_text_write_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/text_write_arbiter_if.sv
// Character offer bus between two requesters and the text write arbiter.
// Each requester presents valid/char and receives a combinational ready.
interface text_write_arbiter_if #(
    parameter int CHAR_ID_LENGTH = 8
);
    logic                      req0_valid;
    logic [CHAR_ID_LENGTH-1:0] req0_char;
    logic                      req0_ready;
    logic                      req1_valid;
    logic [CHAR_ID_LENGTH-1:0] req1_char;
    logic                      req1_ready;

    modport master (
        output req0_valid, req0_char, req1_valid, req1_char,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_char, req1_valid, req1_char,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/text_write_arbiter.sv
// Round-robin arbiter feeding a text character plane: accepts one character per
// transfer, moves the cursor and issues write / scroll / clear strobes.
module text_write_arbiter #(
    parameter int ROW_NUMBER     = 15,
    parameter int COL_NUMBER     = 40,
    parameter int CHAR_ID_LENGTH = 8,
    parameter int ROW_BIT_LEN    = 4,
    parameter int COL_BIT_LEN    = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    text_write_arbiter_if.slave       req,
    output logic [CHAR_ID_LENGTH-1:0] put_character_id,
    output logic [ROW_BIT_LEN-1:0]    put_row,
    output logic [COL_BIT_LEN-1:0]    put_col,
    output logic                      we,
    output logic                      push_up,
    output logic                      clear,
    output logic [ROW_BIT_LEN-1:0]    cursor_row,
    output logic [COL_BIT_LEN-1:0]    cursor_col,
    output logic                      busy
);
    localparam logic [ROW_BIT_LEN-1:0]    LAST_ROW = ROW_BIT_LEN'(ROW_NUMBER - 1);
    localparam logic [COL_BIT_LEN-1:0]    LAST_COL = COL_BIT_LEN'(COL_NUMBER - 1);
    localparam logic [ROW_BIT_LEN-1:0]    ROW_ONE  = ROW_BIT_LEN'(1);
    localparam logic [COL_BIT_LEN-1:0]    COL_ONE  = COL_BIT_LEN'(1);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_BS    = CHAR_ID_LENGTH'(8'h08);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_NL    = CHAR_ID_LENGTH'(8'h0A);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_FF    = CHAR_ID_LENGTH'(8'h0C);
    localparam logic [CHAR_ID_LENGTH-1:0] CH_SPACE = CHAR_ID_LENGTH'(8'h20);

    typedef enum logic [1:0] {IDLE, EXEC, SCROLL} state_t;

    state_t state, state_next;
    logic   ptr, grant_any, grant_idx, transfer, scroll_pend;
    logic [CHAR_ID_LENGTH-1:0] char_in;

    logic                      n_we, n_push, n_clear, n_scroll;
    logic [CHAR_ID_LENGTH-1:0] n_id;
    logic [ROW_BIT_LEN-1:0]    n_row, n_cur_row;
    logic [COL_BIT_LEN-1:0]    n_col, n_cur_col;

    // Pointer names the favoured requester when both offer at once.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr;
        if (req.req0_valid && req.req1_valid) begin
            grant_any = 1'b1;
            grant_idx = ptr;
        end else if (req.req0_valid) begin
            grant_any = 1'b1;
            grant_idx = 1'b0;
        end else if (req.req1_valid) begin
            grant_any = 1'b1;
            grant_idx = 1'b1;
        end
    end

    assign transfer       = (state == IDLE) && grant_any;
    assign req.req0_ready = reset_n && (state == IDLE) && grant_any && !grant_idx;
    assign req.req1_ready = reset_n && (state == IDLE) && grant_any && grant_idx;
    assign char_in        = grant_idx ? req.req1_char : req.req0_char;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (transfer) state_next = EXEC;
            EXEC:    state_next = scroll_pend ? SCROLL : IDLE;
            SCROLL:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Effect of the offered character, evaluated against the current cursor.
    always_comb begin
        n_we      = 1'b0;
        n_push    = 1'b0;
        n_clear   = 1'b0;
        n_scroll  = 1'b0;
        n_id      = put_character_id;
        n_row     = put_row;
        n_col     = put_col;
        n_cur_row = cursor_row;
        n_cur_col = cursor_col;
        case (char_in)
            CH_NL: begin
                n_cur_col = '0;
                if (cursor_row < LAST_ROW) n_cur_row = cursor_row + ROW_ONE;
                else                       n_push    = 1'b1;
            end
            CH_BS: begin
                if (cursor_col != '0) begin
                    n_cur_col = cursor_col - COL_ONE;
                    n_we      = 1'b1;
                end else if (cursor_row != '0) begin
                    n_cur_row = cursor_row - ROW_ONE;
                    n_cur_col = LAST_COL;
                    n_we      = 1'b1;
                end
                if (n_we) begin
                    n_id  = CH_SPACE;
                    n_row = n_cur_row;
                    n_col = n_cur_col;
                end
            end
            CH_FF: begin
                n_clear   = 1'b1;
                n_cur_row = '0;
                n_cur_col = '0;
            end
            default: begin
                n_we  = 1'b1;
                n_id  = char_in;
                n_row = cursor_row;
                n_col = cursor_col;
                if (cursor_col == LAST_COL) begin
                    n_cur_col = '0;
                    if (cursor_row == LAST_ROW) n_scroll  = 1'b1;
                    else                        n_cur_row = cursor_row + ROW_ONE;
                end else begin
                    n_cur_col = cursor_col + COL_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr              <= 1'b0;
            scroll_pend      <= 1'b0;
            we               <= 1'b0;
            push_up          <= 1'b0;
            clear            <= 1'b0;
            put_character_id <= '0;
            put_row          <= '0;
            put_col          <= '0;
            cursor_row       <= '0;
            cursor_col       <= '0;
        end else begin
            we      <= 1'b0;
            push_up <= 1'b0;
            clear   <= 1'b0;
            if (transfer) begin
                ptr              <= ~grant_idx;
                scroll_pend      <= n_scroll;
                we               <= n_we;
                push_up          <= n_push;
                clear            <= n_clear;
                put_character_id <= n_id;
                put_row          <= n_row;
                put_col          <= n_col;
                cursor_row       <= n_cur_row;
                cursor_col       <= n_cur_col;
            end else if (state == EXEC) begin
                push_up     <= scroll_pend;
                scroll_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_text_write_arbiter.sv
// Directed bench for text_write_arbiter: cursor movement, strobes, arbitration, reset.
module tb_text_write_arbiter;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] put_character_id;
    logic [3:0] put_row, cursor_row;
    logic [5:0] put_col, cursor_col;
    logic       we, push_up, clear, busy;
    int         checks = 0;
    int         errors = 0;

    text_write_arbiter_if #(.CHAR_ID_LENGTH(8)) bus();

    text_write_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req(bus),
        .put_character_id(put_character_id), .put_row(put_row), .put_col(put_col),
        .we(we), .push_up(push_up), .clear(clear),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_char = 8'h00; bus.req1_char = 8'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_char(input logic [7:0] c);
        int n;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_char = c;
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL send_idle_timeout: busy=%b required 0", busy); end
    endtask

    task automatic go_to(input int rows, input int cols);
        do_reset();
        repeat (rows) send_char(8'h0A);
        repeat (cols) send_char(8'h61);
    endtask

    // Offer c on req0 at the next negedge; returns #1 after the accepting edge.
    task automatic offer(input logic [7:0] c);
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_char = c;
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_char = 8'h41;
        bus.req1_valid = 1'b1; bus.req1_char = 8'h42;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b required 00", {bus.req0_ready, bus.req1_ready}); end
        checks++; if ({we, push_up, clear, busy} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b required 0000", {we, push_up, clear, busy}); end
        checks++; if ({put_character_id, put_row, put_col} !== 18'h0) begin errors++; $display("FAIL reset_put: got %h required 0", {put_character_id, put_row, put_col}); end
        @(posedge clk); #1;
        checks++; if ({cursor_row, cursor_col} !== 10'h0) begin errors++; $display("FAIL reset_cursor: got %0d,%0d required 0,0", cursor_row, cursor_col); end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_char();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_char = 8'h41;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b required 10", {bus.req0_ready, bus.req1_ready}); end
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        checks++; if ({we, push_up, clear, busy} !== 4'b1001) begin errors++; $display("FAIL single_strobes: got %b required 1001", {we, push_up, clear, busy}); end
        checks++; if ({put_character_id, put_row, put_col} !== {8'h41, 4'd0, 6'd0}) begin errors++; $display("FAIL single_put: got %h/%0d/%0d required 41/0/0", put_character_id, put_row, put_col); end
        checks++; if ({cursor_row, cursor_col} !== {4'd0, 6'd1}) begin errors++; $display("FAIL single_cursor: got %0d,%0d required 0,1", cursor_row, cursor_col); end
        @(posedge clk); #1;
        checks++; if ({we, push_up, clear, busy} !== 4'b0000) begin errors++; $display("FAIL single_idle: got %b required 0000", {we, push_up, clear, busy}); end
        checks++; if (put_character_id !== 8'h41) begin errors++; $display("FAIL single_hold: got %h required 41", put_character_id); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_id;
        logic [1:0] exp_rdy;
        do_reset();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_char = 8'h41;
        bus.req1_valid = 1'b1; bus.req1_char = 8'h42;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k % 2 == 0) begin
                exp_id = ((k / 2) % 2 == 0) ? 8'h41 : 8'h42;
                checks++; if ({we, busy, put_character_id, put_col} !== {2'b11, exp_id, 6'(k / 2)}) begin
                    errors++; $display("FAIL rr_write_%0d: we=%b busy=%b id=%h col=%0d required 1 1 %h %0d", k, we, busy, put_character_id, put_col, exp_id, k / 2);
                end
            end else begin
                exp_rdy = ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if ({we, busy, bus.req0_ready, bus.req1_ready} !== {2'b00, exp_rdy}) begin
                    errors++; $display("FAIL rr_idle_%0d: got %b required %b", k, {we, busy, bus.req0_ready, bus.req1_ready}, {2'b00, exp_rdy});
                end
            end
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if ({cursor_row, cursor_col, busy} !== {4'd0, 6'd3, 1'b0}) begin errors++; $display("FAIL rr_cursor: got %0d,%0d busy=%b required 0,3 busy=0", cursor_row, cursor_col, busy); end
    endtask

    task automatic test_scroll();
        go_to(14, 39);
        checks++; if ({cursor_row, cursor_col} !== {4'd14, 6'd39}) begin errors++; $display("FAIL scroll_setup: got %0d,%0d required 14,39", cursor_row, cursor_col); end
        offer(8'h5A);
        checks++; if ({we, push_up, clear, busy} !== 4'b1001) begin errors++; $display("FAIL scroll_t1_strobes: got %b required 1001", {we, push_up, clear, busy}); end
        checks++; if ({put_character_id, put_row, put_col} !== {8'h5A, 4'd14, 6'd39}) begin errors++; $display("FAIL scroll_t1_put: got %h/%0d/%0d required 5a/14/39", put_character_id, put_row, put_col); end
        checks++; if ({cursor_row, cursor_col} !== {4'd14, 6'd0}) begin errors++; $display("FAIL scroll_t1_cursor: got %0d,%0d required 14,0", cursor_row, cursor_col); end
        @(posedge clk); #1;
        checks++; if ({we, push_up, clear, busy} !== 4'b0101) begin errors++; $display("FAIL scroll_t2_strobes: got %b required 0101", {we, push_up, clear, busy}); end
        checks++; if ({cursor_row, cursor_col} !== {4'd14, 6'd0}) begin errors++; $display("FAIL scroll_t2_cursor: got %0d,%0d required 14,0", cursor_row, cursor_col); end
        @(posedge clk); #1;
        checks++; if ({we, push_up, clear, busy} !== 4'b0000) begin errors++; $display("FAIL scroll_t3_strobes: got %b required 0000", {we, push_up, clear, busy}); end
    endtask

    task automatic test_backspace();
        go_to(3, 0);
        offer(8'h08);
        checks++; if ({we, push_up, clear, busy} !== 4'b1001) begin errors++; $display("FAIL bs_wrap_strobes: got %b required 1001", {we, push_up, clear, busy}); end
        checks++; if ({put_character_id, put_row, put_col} !== {8'h20, 4'd2, 6'd39}) begin errors++; $display("FAIL bs_wrap_put: got %h/%0d/%0d required 20/2/39", put_character_id, put_row, put_col); end
        checks++; if ({cursor_row, cursor_col} !== {4'd2, 6'd39}) begin errors++; $display("FAIL bs_wrap_cursor: got %0d,%0d required 2,39", cursor_row, cursor_col); end
        @(posedge clk);
        offer(8'h08);
        checks++; if ({we, put_character_id, put_row, put_col} !== {1'b1, 8'h20, 4'd2, 6'd38}) begin errors++; $display("FAIL bs_col_put: we=%b %h/%0d/%0d required 1 20/2/38", we, put_character_id, put_row, put_col); end
        checks++; if ({cursor_row, cursor_col} !== {4'd2, 6'd38}) begin errors++; $display("FAIL bs_col_cursor: got %0d,%0d required 2,38", cursor_row, cursor_col); end
        @(posedge clk);
        do_reset();
        offer(8'h08);
        checks++; if ({we, push_up, clear, busy} !== 4'b0001) begin errors++; $display("FAIL bs_origin_strobes: got %b required 0001", {we, push_up, clear, busy}); end
        checks++; if ({cursor_row, cursor_col, put_character_id} !== {4'd0, 6'd0, 8'h00}) begin errors++; $display("FAIL bs_origin_state: got %0d,%0d id=%h required 0,0 id=00", cursor_row, cursor_col, put_character_id); end
        @(posedge clk);
    endtask

    task automatic test_newline_clear();
        go_to(14, 10);
        offer(8'h0A);
        checks++; if ({we, push_up, clear, busy} !== 4'b0101) begin errors++; $display("FAIL nl_last_strobes: got %b required 0101", {we, push_up, clear, busy}); end
        checks++; if ({cursor_row, cursor_col} !== {4'd14, 6'd0}) begin errors++; $display("FAIL nl_last_cursor: got %0d,%0d required 14,0", cursor_row, cursor_col); end
        checks++; if ({put_character_id, put_row, put_col} !== {8'h61, 4'd14, 6'd9}) begin errors++; $display("FAIL nl_put_hold: got %h/%0d/%0d required 61/14/9", put_character_id, put_row, put_col); end
        @(posedge clk); #1;
        checks++; if ({we, push_up, clear, busy} !== 4'b0000) begin errors++; $display("FAIL nl_no_scroll: got %b required 0000", {we, push_up, clear, busy}); end
        offer(8'h0C);
        checks++; if ({we, push_up, clear, busy} !== 4'b0011) begin errors++; $display("FAIL clr_strobes: got %b required 0011", {we, push_up, clear, busy}); end
        checks++; if ({cursor_row, cursor_col} !== {4'd0, 6'd0}) begin errors++; $display("FAIL clr_cursor: got %0d,%0d required 0,0", cursor_row, cursor_col); end
        @(posedge clk);
    endtask

    task automatic test_reset_in_scroll();
        go_to(14, 39);
        offer(8'h5A);
        @(posedge clk); #1;
        checks++; if (push_up !== 1'b1) begin errors++; $display("FAIL rst_scroll_pre: push_up=%b required 1", push_up); end
        #2 reset_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_char = 8'h33;
        #1;
        checks++; if ({we, push_up, clear, busy, bus.req0_ready} !== 5'b00000) begin errors++; $display("FAIL rst_scroll_strobes: got %b required 00000", {we, push_up, clear, busy, bus.req0_ready}); end
        checks++; if ({put_character_id, put_row, put_col, cursor_row, cursor_col} !== 28'h0) begin errors++; $display("FAIL rst_scroll_regs: got %h required 0", {put_character_id, put_row, put_col, cursor_row, cursor_col}); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        checks++; if ({we, put_character_id, put_row, put_col} !== {1'b1, 8'h33, 4'd0, 6'd0}) begin errors++; $display("FAIL rst_scroll_next: we=%b %h/%0d/%0d required 1 33/0/0", we, put_character_id, put_row, put_col); end
        @(posedge clk);
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_char = 8'h00; bus.req1_char = 8'h00;
        test_reset();
        test_single_char();
        test_round_robin();
        test_scroll();
        test_backspace();
        test_newline_clear();
        test_reset_in_scroll();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
